irq_pending_encoder: RTL and testbench
======================================

Name: irq_pending_encoder

Overview:
- Downstream consumer of the 4-to-2 priority encoder function. Captures events on 4 request lines into a pending register and encodes pending & mask by priority (bit 3 highest).
- Offers the winning index with a valid/ack handshake and clears the serviced bit on acceptance.
- Sits between raw request sources and a single service engine, e.g. an interrupt dispatcher.

Parameters:
- EDGE, 1, 1 = capture rising edges of d; 0 = capture d as a level every cycle
- N, 4, number of request lines; fixed at 4 in this revision, q width is 2

Ports:
- clk  input  1  single clock; all state changes on its rising edge
- reset_n  input  1  asynchronous, active-low reset
- d  input  4  request lines, synchronous to clk
- mask  input  4  per-line enable; 1 = line may win arbitration
- q  output  2  index of the offered request; valid only while v=1
- v  output  1  an offer is presented
- ack  input  1  consumer accepts the offer; fire = v & ack
- pending  output  4  current pending register
- ovf  output  4  sticky per-line overflow flags
- clear_ovf  input  1  clears all ovf bits

Behaviour:
- Reset: asserting reset_n low immediately clears d_prev, pending, ovf, q, v and state to 0 / IDLE, including mid-offer. No ack is needed.
- Capture:
  - EDGE=1: set = d & ~d_prev, with d_prev <= d every cycle.
  - EDGE=0: set = d.
  - Because d_prev resets to 0, a line held high across reset release generates exactly one event on the first clock.
- clr: the one-hot of q when fire, else 0.
- pending update: pending <= (pending & ~clr) | set. If set and clr hit the same bit in one cycle, set wins and the bit stays 1 (the new event is kept).
- Overflow: ovf[i] <= 1 when set[i] & pending[i] & ~clr[i]. clear_ovf clears all bits. If clear_ovf coincides with a new overflow on bit i, ovf[i] ends at 1.
- FSM, two states:
  - IDLE: v=0. If (pending & mask) != 0, load q = index of the highest set bit of (pending & mask), set v=1 and go to OFFER. Otherwise stay in IDLE.
  - OFFER: v=1 and q is held stable. Mask changes and new higher-priority requests do not retract or change the offer. On fire: clear pending[q], set v=0, go to IDLE.
- ack is ignored in IDLE.
- Masked requests stay pending and are offered once unmasked.
- Latency (EDGE=1):
  - d rises before edge t, so set is seen at edge t and pending is set after edge t.
  - FSM evaluates pending at edge t+1, so v=1 after edge t+1: 2 cycles from request to offer.
- Throughput: at most one grant per 2 cycles, because IDLE always inserts one cycle between grants.
- q outside an offer holds its last value; consumers must qualify q with v.
- All outputs are registered; there is no combinational path from d or mask to q or v.

Test Plan:
- Reset, then mask=4'b1111 and d pulses 4'b0100 for one cycle:
  - pending=4'b0100 after 1 edge; v=1, q=2 after 2 edges.
  - ack=1 for one cycle gives v=0 and pending=0.
- d=4'b1001 in one cycle, ack held high:
  - Offers q=3, then q=0, with one v=0 cycle between them.
  - Final state pending=0, ovf=0.
- While in OFFER with q=1, raise d[3]:
  - q stays 1 until ack, then the next offer is q=3.
  - mask=4'b0000 mid-offer does not drop v.
- mask=4'b0001 with d events on bits 2 and 0: only q=0 is offered and pending=4'b0100 remains. Setting mask=4'b1111 then offers q=2.
- Second rising edge on d[1] while pending[1]=1 and no ack: ovf=4'b0010 and stays set. clear_ovf=1 gives ovf=0.
- Same-cycle set/clear: ack of q=1 in the same cycle d[1] rises gives pending[1]=1 afterwards and ovf[1]=0.
- Reset mid-offer: v=1, q=2, drive reset_n=0 between edges. v, pending and ovf go to 0 immediately.
- Held-high d after reset release: d=4'b0001 held through reset release gives exactly one event, offered as q=0.

Source files
------------

// File: rtl/irq_pending_encoder_if.sv
// Request/offer bundle between request sources, the pending encoder and its service engine.
// master drives requests, mask, ack and clear_ovf; slave returns the offer and status.
interface irq_pending_encoder_if #(
  parameter int N = 4
);
  logic [N-1:0]         d;
  logic [N-1:0]         mask;
  logic [$clog2(N)-1:0] q;
  logic                 v;
  logic                 ack;
  logic [N-1:0]         pending;
  logic [N-1:0]         ovf;
  logic                 clear_ovf;

  modport master (
    output d, mask, ack, clear_ovf,
    input  q, v, pending, ovf
  );

  modport slave (
    input  d, mask, ack, clear_ovf,
    output q, v, pending, ovf
  );
endinterface

// File: rtl/irq_pending_encoder.sv
// Latches request events into a pending register and offers the highest-priority unmasked one; 2 cycles request-to-offer.
// The offer is held stable until ack; the IDLE state between grants limits throughput to one grant per 2 cycles.
module irq_pending_encoder #(
  parameter bit EDGE = 1'b1,
  parameter int N    = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  irq_pending_encoder_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] d_prev_q;
  logic [N-1:0] pending_q, pending_d;
  logic [N-1:0] ovf_q, ovf_d;
  logic [1:0]   idx_q, idx_d;

  logic [N-1:0] set_w;
  logic [N-1:0] clr_w;
  logic [N-1:0] pm_w;
  logic [1:0]   enc_w;
  logic         v_w;
  logic         fire_w;

  assign set_w = EDGE ? (bus.d & ~d_prev_q) : bus.d;
  assign pm_w  = pending_q & bus.mask;

  // Ascending scan so the highest set bit wins.
  always_comb begin
    enc_w = 2'd0;
    for (int i = 0; i < N; i++) begin
      if (pm_w[i]) enc_w = i[1:0];
    end
  end

  // A new event on the bit being serviced survives the clear.
  assign pending_d = (pending_q & ~clr_w) | set_w;
  assign ovf_d     = (bus.clear_ovf ? '0 : ovf_q) | (set_w & pending_q & ~clr_w);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idx_q     <= 2'd0;
      d_prev_q  <= '0;
      pending_q <= '0;
      ovf_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      d_prev_q  <= bus.d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (|pm_w) begin
          state_d = OFFER;
          idx_d   = enc_w;
        end
      end
      OFFER: begin
        if (bus.ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    v_w    = (state_q == OFFER);
    fire_w = v_w & bus.ack;
    clr_w  = fire_w ? ({{(N-1){1'b0}}, 1'b1} << idx_q) : '0;
  end

  assign bus.v       = v_w;
  assign bus.q       = idx_q;
  assign bus.pending = pending_q;
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_irq_pending_encoder.sv
// Directed test of irq_pending_encoder: capture, priority, hold-under-offer, masking, overflow and reset.
module tb_irq_pending_encoder;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  irq_pending_encoder_if bus ();

  irq_pending_encoder #(.EDGE(1'b1), .N(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    reset_n       = 1'b0;
    bus.d         = 4'b0000;
    bus.mask      = 4'b0000;
    bus.ack       = 1'b0;
    bus.clear_ovf = 1'b0;
    repeat (3) tick();
    chk("rst_v", 32'(bus.v), 32'd0);
    chk("rst_q", 32'(bus.q), 32'd0);
    chk("rst_pending", 32'(bus.pending), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    reset_n = 1'b1;
    tick();

    // Single pulse on bit 2
    bus.mask = 4'b1111;
    bus.d    = 4'b0100;
    tick();
    bus.d = 4'b0000;
    chk("t1_pending", 32'(bus.pending), 32'h4);
    chk("t1_v_early", 32'(bus.v), 32'd0);
    tick();
    chk("t1_v", 32'(bus.v), 32'd1);
    chk("t1_q", 32'(bus.q), 32'd2);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("t1_v_after_ack", 32'(bus.v), 32'd0);
    chk("t1_pending_after_ack", 32'(bus.pending), 32'd0);

    // Two simultaneous events with ack held high
    bus.d   = 4'b1001;
    bus.ack = 1'b1;
    tick();
    bus.d = 4'b0000;
    chk("t2_pending", 32'(bus.pending), 32'h9);
    tick();
    chk("t2_v_first", 32'(bus.v), 32'd1);
    chk("t2_q_first", 32'(bus.q), 32'd3);
    tick();
    chk("t2_gap_v", 32'(bus.v), 32'd0);
    chk("t2_gap_pending", 32'(bus.pending), 32'h1);
    tick();
    chk("t2_v_second", 32'(bus.v), 32'd1);
    chk("t2_q_second", 32'(bus.q), 32'd0);
    tick();
    bus.ack = 1'b0;
    chk("t2_v_end", 32'(bus.v), 32'd0);
    chk("t2_pending_end", 32'(bus.pending), 32'd0);
    chk("t2_ovf_end", 32'(bus.ovf), 32'd0);

    // Offer of q=1 is not displaced by a higher request or by masking
    bus.d = 4'b0010;
    tick();
    bus.d = 4'b0000;
    tick();
    chk("t3_q_initial", 32'(bus.q), 32'd1);
    bus.d = 4'b1000;
    tick();
    bus.d = 4'b0000;
    chk("t3_q_hold", 32'(bus.q), 32'd1);
    chk("t3_pending_both", 32'(bus.pending), 32'hA);
    bus.mask = 4'b0000;
    tick();
    chk("t3_v_masked", 32'(bus.v), 32'd1);
    chk("t3_q_masked", 32'(bus.q), 32'd1);
    bus.mask = 4'b1111;
    bus.ack  = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("t3_v_gap", 32'(bus.v), 32'd0);
    chk("t3_pending_gap", 32'(bus.pending), 32'h8);
    tick();
    chk("t3_v_next", 32'(bus.v), 32'd1);
    chk("t3_q_next", 32'(bus.q), 32'd3);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;

    // Masked request stays pending until unmasked
    bus.mask = 4'b0001;
    bus.d    = 4'b0101;
    tick();
    bus.d = 4'b0000;
    tick();
    chk("t4_v", 32'(bus.v), 32'd1);
    chk("t4_q", 32'(bus.q), 32'd0);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    tick();
    chk("t4_v_masked_idle", 32'(bus.v), 32'd0);
    chk("t4_pending_kept", 32'(bus.pending), 32'h4);
    bus.mask = 4'b1111;
    tick();
    chk("t4_v_unmasked", 32'(bus.v), 32'd1);
    chk("t4_q_unmasked", 32'(bus.q), 32'd2);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("t4_pending_end", 32'(bus.pending), 32'd0);

    // Overflow on a second event to a still-pending line
    bus.d = 4'b0010;
    tick();
    bus.d = 4'b0000;
    tick();
    bus.d = 4'b0010;
    tick();
    bus.d = 4'b0000;
    chk("t5_ovf_set", 32'(bus.ovf), 32'h2);
    tick();
    chk("t5_ovf_sticky", 32'(bus.ovf), 32'h2);
    bus.clear_ovf = 1'b1;
    tick();
    bus.clear_ovf = 1'b0;
    chk("t5_ovf_cleared", 32'(bus.ovf), 32'd0);
    chk("t5_still_offer", 32'(bus.q), 32'd1);

    // Same-cycle set and clear on bit 1: the new event is kept
    bus.ack = 1'b1;
    bus.d   = 4'b0010;
    tick();
    bus.ack = 1'b0;
    bus.d   = 4'b0000;
    chk("t6_pending_kept", 32'(bus.pending), 32'h2);
    chk("t6_ovf_none", 32'(bus.ovf), 32'd0);
    chk("t6_v_gap", 32'(bus.v), 32'd0);
    tick();
    chk("t6_reoffer_q", 32'(bus.q), 32'd1);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;

    // Asynchronous reset in the middle of an offer with ovf set
    bus.d = 4'b0100;
    tick();
    bus.d = 4'b0000;
    tick();
    bus.d = 4'b0100;
    tick();
    bus.d = 4'b0000;
    chk("t7_pre_v", 32'(bus.v), 32'd1);
    chk("t7_pre_ovf", 32'(bus.ovf), 32'h4);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t7_rst_v", 32'(bus.v), 32'd0);
    chk("t7_rst_pending", 32'(bus.pending), 32'd0);
    chk("t7_rst_ovf", 32'(bus.ovf), 32'd0);

    // Line held high through reset release yields exactly one event
    bus.d = 4'b0001;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("t8_pending", 32'(bus.pending), 32'h1);
    tick();
    chk("t8_v", 32'(bus.v), 32'd1);
    chk("t8_q", 32'(bus.q), 32'd0);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    tick();
    tick();
    chk("t8_no_second_v", 32'(bus.v), 32'd0);
    chk("t8_no_second_pending", 32'(bus.pending), 32'd0);
    bus.d = 4'b0000;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
